// File: rtl/noc_link_arbiter.sv
// Packet-granular round-robin arbiter driving one credit-flow-controlled NoC link.
// Grants lock to one input from head flit to tail flit; link outputs are registered.
module noc_link_arbiter #(
   parameter int NUM_INPUTS   = 4,
   parameter int FLIT_WIDTH   = 128,
   parameter int DEST_WIDTH   = 8,
   parameter int BUFFER_DEPTH = 8,
   parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS*DEST_WIDTH-1:0] in_dest,
   input  logic [NUM_INPUTS-1:0]            in_is_tail,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]            data_out,
   output logic [DEST_WIDTH-1:0]            dest_out,
   output logic                             is_tail_out,
   output logic                             send_out,
   input  logic                             credit_in,
   output logic [CREDIT_WIDTH-1:0]          credit_count,
   output logic                             locked,
   output logic                             credit_overflow
);

   localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int CW1   = CREDIT_WIDTH + 1;

   // Handshake: a flit moves on input i in any cycle where in_valid[i] && in_ready[i];
   // in_ready never depends on the same cycle's in_ready, and in_valid must not depend on it.
   typedef enum logic {S_OPEN, S_LOCKED} state_t;

   state_t                  state, state_nxt;
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]        owner, owner_nxt;
   logic [PTR_W-1:0]        grant_idx;
   logic [PTR_W-1:0]        cand;
   logic                    grant_valid;
   logic                    accept;
   logic [FLIT_WIDTH-1:0]   sel_data;
   logic [DEST_WIDTH-1:0]   sel_dest;
   logic                    sel_tail;
   logic [CW1-1:0]          credit_sum;
   logic                    credit_over;
   logic [CREDIT_WIDTH-1:0] credit_nxt;

   // Requester selection: locked owner only, otherwise first valid input from rr_ptr upward.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (state == S_LOCKED) begin
         grant_valid = in_valid[owner];
         grant_idx   = owner;
      end else begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (!grant_valid && in_valid[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   assign accept   = grant_valid && (credit_count != '0);
   assign in_ready = accept ? (NUM_INPUTS'(1) << grant_idx) : '0;
   assign sel_data = in_data[int'(grant_idx)*FLIT_WIDTH +: FLIT_WIDTH];
   assign sel_dest = in_dest[int'(grant_idx)*DEST_WIDTH +: DEST_WIDTH];
   assign sel_tail = in_is_tail[grant_idx];
   assign locked   = (state == S_LOCKED);

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      if (accept) begin
         if (sel_tail) begin
            state_nxt  = S_OPEN;
            rr_ptr_nxt = (grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + PTR_W'(1);
         end else begin
            state_nxt = S_LOCKED;
            owner_nxt = grant_idx;
         end
      end
   end

   // accept implies credit_count > 0, so the subtraction cannot wrap.
   always_comb begin
      credit_sum  = {1'b0, credit_count} + CW1'(credit_in) - CW1'(accept);
      credit_over = (credit_sum > CW1'(BUFFER_DEPTH));
      credit_nxt  = credit_over ? CREDIT_WIDTH'(BUFFER_DEPTH) : credit_sum[CREDIT_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_OPEN;
         owner           <= '0;
         rr_ptr          <= '0;
         credit_count    <= CREDIT_WIDTH'(BUFFER_DEPTH);
         credit_overflow <= 1'b0;
         send_out        <= 1'b0;
         data_out        <= '0;
         dest_out        <= '0;
         is_tail_out     <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         rr_ptr       <= rr_ptr_nxt;
         credit_count <= credit_nxt;
         send_out     <= accept;
         if (credit_over) begin
            credit_overflow <= 1'b1;
         end
         if (accept) begin
            data_out    <= sel_data;
            dest_out    <= sel_dest;
            is_tail_out <= sel_tail;
         end
      end
   end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Bench for noc_link_arbiter: directed scenarios plus random traffic, checked against
// a rule-level reference model and a scoreboard of expected link flits.
module tb_noc_link_arbiter;

   localparam int N     = 4;
   localparam int FW    = 32;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk;
   logic            rst;
   logic [N*FW-1:0] in_data;
   logic [N*DW-1:0] in_dest;
   logic [N-1:0]    in_is_tail;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [FW-1:0]   data_out;
   logic [DW-1:0]   dest_out;
   logic            is_tail_out;
   logic            send_out;
   logic            credit_in;
   logic [CW-1:0]   credit_count;
   logic            locked;
   logic            credit_overflow;

   noc_link_arbiter #(
      .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
      .in_is_tail(in_is_tail), .in_valid(in_valid), .in_ready(in_ready),
      .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
      .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
      .locked(locked), .credit_overflow(credit_overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state (packet-level rules)
   int            m_credits;
   int            m_ptr;
   int            m_owner;
   bit            m_locked;
   bit            m_ovf;
   bit            m_send;
   logic [FW-1:0] m_data;
   logic [DW-1:0] m_dest;
   bit            m_tail;
   logic [FW-1:0] exp_q[$];
   int            dut_log[$];
   int            send_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      if (m_credits == 0) return -1;
      if (m_locked) return in_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_credits = DEPTH; m_ptr = 0; m_owner = 0; m_locked = 0; m_ovf = 0;
      m_send = 0; m_data = '0; m_dest = '0; m_tail = 0;
      exp_q.delete();
   endtask

   // driver tasks
   task automatic rand_payload();
      for (int i = 0; i < N; i++) begin
         in_data[i*FW +: FW] = $urandom;
         in_dest[i*DW +: DW] = DW'($urandom_range(0, 255));
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] t, input logic c);
      in_valid = v; in_is_tail = t; credit_in = c;
      rand_payload();
   endtask

   // one clock: check combinational in_ready, advance model, check registered outputs
   task automatic tick();
      int g;
      int nc;
      logic [N-1:0] er;
      #1;
      g  = model_grant();
      er = (g < 0) ? '0 : (N'(1) << g);
      chk("in_ready", in_ready, er);
      for (int i = 0; i < N; i++) if (in_ready[i]) dut_log.push_back(i);
      @(posedge clk);
      m_send = (g >= 0);
      if (g >= 0) begin
         exp_q.push_back(in_data[g*FW +: FW]);
         m_data = in_data[g*FW +: FW];
         m_dest = in_dest[g*DW +: DW];
         m_tail = in_is_tail[g];
         if (m_tail) begin m_locked = 0; m_ptr = (g + 1) % N; end
         else begin m_locked = 1; m_owner = g; end
      end
      nc = m_credits - ((g >= 0) ? 1 : 0) + (credit_in ? 1 : 0);
      if (nc > DEPTH) begin nc = DEPTH; m_ovf = 1; end
      m_credits = nc;
      @(negedge clk);
      chk("send_out", send_out, m_send);
      if (m_send) chk("scoreboard_flit", data_out, exp_q.pop_front());
      chk("data_out", data_out, m_data);
      chk("dest_out", dest_out, m_dest);
      chk("is_tail_out", is_tail_out, m_tail);
      chk("credit_count", credit_count, m_credits);
      chk("locked", locked, m_locked);
      chk("credit_overflow", credit_overflow, m_ovf);
      if (send_out === 1'b1) send_cnt++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, '0, 1'b0);
      #1;
      chk("rst_credit", credit_count, DEPTH);
      chk("rst_locked", locked, 0);
      chk("rst_send", send_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ovf", credit_overflow, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      dut_log.delete();
      send_cnt = 0;
   endtask

   initial begin
      bit s1, s2;
      rst = 1'b1;
      in_data = '0; in_dest = '0; in_is_tail = '0; in_valid = '0; credit_in = 1'b0;
      model_reset();

      // 1: inputs 0 and 2 alternate, credits looped back two cycles after each send
      do_reset();
      s1 = 0; s2 = 0;
      for (int c = 0; c < 12; c++) begin
         drive(4'b0101, 4'b1111, s2);
         tick();
         s2 = s1; s1 = m_send;
         chk("t1_credit_range", (credit_count >= 6 && credit_count <= 8), 1);
      end
      for (int k = 0; k < 8; k++) chk("t1_grant_order", dut_log[k], (k % 2 == 0) ? 0 : 2);

      // 2: 3-flit packet on input 1 with a 2-cycle gap, input 3 valid throughout
      do_reset();
      drive(4'b1010, 4'b1000, 1'b0); tick();
      chk("t2_locked_after_head", locked, 1);
      for (int c = 0; c < 2; c++) begin
         drive(4'b1000, 4'b1000, 1'b0); tick();
         chk("t2_bubble_ready", in_ready, 0);
         chk("t2_bubble_send", send_out, 0);
      end
      drive(4'b1010, 4'b1000, 1'b0); tick();
      drive(4'b1010, 4'b1010, 1'b0); tick();
      chk("t2_unlocked_after_tail", locked, 0);
      drive(4'b1000, 4'b1000, 1'b0); tick();
      chk("t2_len", dut_log.size(), 4);
      for (int k = 0; k < 4; k++) chk("t2_grant_order", dut_log[k], (k < 3) ? 1 : 3);

      // 3: credit exhaustion, then a single returned credit
      do_reset();
      for (int c = 0; c < 12; c++) begin drive(4'b1111, 4'b1111, 1'b0); tick(); end
      chk("t3_sends", send_cnt, 8);
      chk("t3_empty_credit", credit_count, 0);
      chk("t3_no_ready", in_ready, 0);
      drive(4'b1111, 4'b1111, 1'b1); tick();
      send_cnt = 0;
      for (int c = 0; c < 3; c++) begin drive(4'b1111, 4'b1111, 1'b0); tick(); end
      chk("t3_one_more_send", send_cnt, 1);

      // 4: simultaneous accept + credit, then overflow saturation
      for (int c = 0; c < 3; c++) begin drive('0, '0, 1'b1); tick(); end
      chk("t4_count3", credit_count, 3);
      drive(4'b0001, 4'b1111, 1'b1); tick();
      chk("t4_hold3", credit_count, 3);
      for (int c = 0; c < 5; c++) begin drive('0, '0, 1'b1); tick(); end
      chk("t4_full_no_ovf", credit_overflow, 0);
      drive('0, '0, 1'b1); tick();
      chk("t4_sat", credit_count, DEPTH);
      chk("t4_ovf", credit_overflow, 1);
      for (int c = 0; c < 3; c++) begin drive('0, '0, 1'b0); tick(); end
      chk("t4_ovf_sticky", credit_overflow, 1);

      // 5: asynchronous reset in the middle of a locked packet
      do_reset();
      for (int c = 0; c < 3; c++) begin drive(4'b0010, 4'b0000, 1'b0); tick(); end
      chk("t5_locked", locked, 1);
      chk("t5_count5", credit_count, 5);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_send", send_out, 0);
      chk("t5_async_data", data_out, 0);
      chk("t5_async_dest", dest_out, 0);
      chk("t5_async_tail", is_tail_out, 0);
      chk("t5_async_credit", credit_count, DEPTH);
      chk("t5_async_locked", locked, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      dut_log.delete();
      drive(4'b1111, 4'b1111, 1'b0); tick();
      chk("t5_restart_from_0", dut_log[0], 0);

      // 6: all inputs busy, unlimited credits -> strict rotation with wrap
      do_reset();
      for (int c = 0; c < 10; c++) begin drive(4'b1111, 4'b1111, 1'b1); tick(); end
      chk("t6_len", dut_log.size(), 10);
      for (int k = 0; k < 10; k++) chk("t6_rotation", dut_log[k], k % 4);

      // random traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
               1'($urandom_range(0, 99) < 45));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
